ram_write_arbiter: RTL and testbench

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

---
 rtl/ram_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/ram_write_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding, requester indices and helpers for the RAM write arbiter.
// RAMWR_STOP_ON_FULL_EN adds the terminal StFull state.
package ram_ctrl_pkg;

`ifdef RAMWR_STOP_ON_FULL_EN
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StRecover = 2'd2,
        StFull    = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StRecover = 2'd2
    } state_e;
`endif

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

    localparam int unsigned BYTEEN_W     = 8;
    localparam logic [7:0]  BYTEEN_RESET = 8'hFF;

    // Pointer value after reset: "last granted was 1" so requester 0 wins a tie.
    localparam logic LAST_RESET = 1'b1;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin arbiter producing a one-hot grant.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = idx_to_onehot(1'b0);
            2'b10:   grant = idx_to_onehot(1'b1);
            // On a tie the requester not served last time wins.
            2'b11:   grant = idx_to_onehot(~last_grant);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter funnelling two write requesters into one RAM write port.
// RAMWR_STOP_ON_FULL_EN: stop in FULL after the last address instead of wrapping.
module ram_write_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_START = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_req,
    input  logic [DATA_W-1:0]   i_data0,
    input  logic [DATA_W-1:0]   i_data1,
    input  logic [BYTEEN_W-1:0] i_byteen0,
    input  logic [BYTEEN_W-1:0] i_byteen1,
    output logic [1:0]          o_ack,
    output logic [DATA_W-1:0]   o_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic [BYTEEN_W-1:0] o_byteen,
    output logic                o_wbit,
    output logic                o_wrapped,
    output logic                o_busy
);

    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(ADDR_START);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BYTEEN_W-1:0] byteen_q, byteen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wrapped_q, wrapped_d;
    logic                last_q, last_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          grant;

    rr_arbiter2 u_rr_arbiter2 (
        .req        (i_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            data_q    <= '0;
            byteen_q  <= BYTEEN_RESET;
            addr_q    <= ADDR_INIT;
            wrapped_q <= 1'b0;
            last_q    <= LAST_RESET;
            grant_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            byteen_q  <= byteen_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        byteen_d  = byteen_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        last_d    = last_q;
        grant_d   = grant_q;

        unique case (state_q)
            StIdle: begin
                if (|i_req) begin
                    grant_d  = grant;
                    last_d   = grant[REQ1];
                    data_d   = grant[REQ1] ? i_data1 : i_data0;
                    byteen_d = grant[REQ1] ? i_byteen1 : i_byteen0;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                state_d = StRecover;
            end
            StRecover: begin
                if (addr_q == ADDR_LAST) begin
                    wrapped_d = 1'b1;
`ifdef RAMWR_STOP_ON_FULL_EN
                    state_d   = StFull;
`else
                    addr_d    = '0;
                    state_d   = StIdle;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StIdle;
                end
            end
`ifdef RAMWR_STOP_ON_FULL_EN
            StFull: begin
                state_d = StFull;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Decoded straight from the state register so an async reset drops them at once.
    assign o_wbit    = (state_q == StWrite);
    assign o_ack     = o_wbit ? grant_q : 2'b00;
    assign o_busy    = (state_q != StIdle);
    assign o_data    = data_q;
    assign o_byteen  = byteen_q;
    assign o_address = addr_q;
    assign o_wrapped = wrapped_q;

    ack_onehot_a : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_ack));
    wbit_single_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                     o_wbit |=> !o_wbit);

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench for ram_write_arbiter: table-driven writes with a scoreboard,
// plus hand sequences for back-to-back grants, mid-write reset and address wrap.
module tb_ram_write_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 64;

    typedef struct {
        logic [1:0]        req;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [7:0]        be0;
        logic [7:0]        be1;
        logic [1:0]        ack;
    } vec_t;

    typedef struct {
        logic [1:0]        ack;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [7:0]        be;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        i_req = 2'b00;
    logic [DATA_W-1:0] i_data0 = '0;
    logic [DATA_W-1:0] i_data1 = '0;
    logic [7:0]        i_byteen0 = '0;
    logic [7:0]        i_byteen1 = '0;
    logic [1:0]        o_ack;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_address;
    logic [7:0]        o_byteen;
    logic              o_wbit;
    logic              o_wrapped;
    logic              o_busy;

    logic [1:0]        w_req = 2'b00;
    logic [DATA_W-1:0] w_data0 = '0;
    logic [7:0]        w_byteen0 = '0;
    logic [1:0]        w_ack;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_address;
    logic [7:0]        w_byteen;
    logic              w_wbit;
    logic              w_wrapped;
    logic              w_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ADDR_START (1)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (i_req),
        .i_data0   (i_data0),
        .i_data1   (i_data1),
        .i_byteen0 (i_byteen0),
        .i_byteen1 (i_byteen1),
        .o_ack     (o_ack),
        .o_data    (o_data),
        .o_address (o_address),
        .o_byteen  (o_byteen),
        .o_wbit    (o_wbit),
        .o_wrapped (o_wrapped),
        .o_busy    (o_busy)
    );

    ram_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ADDR_START (16383)
    ) u_wrap (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (w_req),
        .i_data0   (w_data0),
        .i_data1   ('0),
        .i_byteen0 (w_byteen0),
        .i_byteen1 (8'h00),
        .o_ack     (w_ack),
        .o_data    (w_data),
        .o_address (w_address),
        .o_byteen  (w_byteen),
        .o_wbit    (w_wbit),
        .o_wrapped (w_wrapped),
        .o_busy    (w_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a write pulse, then compare it against the scoreboard head.
    task automatic wait_write(input int budget, output int at_cyc);
        bit   seen;
        int   k;
        exp_t e;
        seen   = 1'b0;
        k      = 0;
        at_cyc = -1;
        while (!seen && k < budget) begin
            @(negedge clk);
            k++;
            if (o_wbit) begin
                seen = 1'b1;
            end else if (o_ack !== 2'b00) begin
                errors++;
                $display("FAIL ack_outside_write: got %b expected 00", o_ack);
            end
        end
        chk("write_seen", 64'(seen), 64'd1);
        if (seen) begin
            at_cyc = cyc;
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                chk("wr_ack", 64'(o_ack), 64'(e.ack));
                chk("wr_addr", 64'(o_address), 64'(e.addr));
                chk("wr_data", o_data, e.data);
                chk("wr_byteen", 64'(o_byteen), 64'(e.be));
            end
        end
    endtask

    initial begin
        int               c[4];
        int               dummy;
        logic [ADDR_W-1:0] exp_addr;
        exp_t             e;
        bit               seen;
        int               k;
        int               acks;

        // ack column derived by hand from the round-robin rule (reset favours 0)
        vecs[0] = '{2'b01, 64'h0001_0002_0003_0004, 64'h0, 8'hFF, 8'h00, 2'b01};
        vecs[1] = '{2'b10, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 8'h0F, 2'b10};
        vecs[2] = '{2'b11, 64'h1111_0000_1111_0000, 64'h2222_0000_2222_0000, 8'h81, 8'h42, 2'b01};
        vecs[3] = '{2'b11, 64'h3333_3333_0000_0000, 64'h4444_4444_0000_0000, 8'h18, 8'h24, 2'b10};
        vecs[4] = '{2'b01, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 8'hF0, 8'h0F, 2'b01};
        vecs[5] = '{2'b01, 64'h7777_0000_0000_7777, 64'h8888_0000_0000_8888, 8'h01, 8'h80, 2'b01};
        vecs[6] = '{2'b11, 64'h9999_9999_9999_0000, 64'hAAAA_AAAA_AAAA_0000, 8'h03, 8'hC0, 2'b10};
        vecs[7] = '{2'b10, 64'hBBBB_0000_BBBB_0000, 64'hCCCC_0000_CCCC_0000, 8'h11, 8'h22, 2'b10};
        vecs[8] = '{2'b11, 64'hDDDD_DDDD_0000_0001, 64'hEEEE_EEEE_0000_0002, 8'h33, 8'h44, 2'b01};

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wbit", 64'(o_wbit), 64'd0);
        chk("rst_ack", 64'(o_ack), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_byteen", 64'(o_byteen), 64'hFF);
        chk("rst_addr", 64'(o_address), 64'd1);
        chk("rst_wrapped", 64'(o_wrapped), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_wrap_addr", 64'(w_address), 64'd16383);
        rst_n = 1'b1;

        // Table-driven writes
        exp_addr = ADDR_W'(1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            i_req     = vecs[i].req;
            i_data0   = vecs[i].d0;
            i_data1   = vecs[i].d1;
            i_byteen0 = vecs[i].be0;
            i_byteen1 = vecs[i].be1;
            e.ack  = vecs[i].ack;
            e.addr = exp_addr;
            e.data = (vecs[i].ack == 2'b10) ? vecs[i].d1 : vecs[i].d0;
            e.be   = (vecs[i].ack == 2'b10) ? vecs[i].be1 : vecs[i].be0;
            sb.push_back(e);
            exp_addr = exp_addr + 1'b1;
            wait_write(8, dummy);
        end
        @(posedge clk);
        #1 i_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("tbl_addr_after", 64'(o_address), 64'(exp_addr));
        chk("tbl_busy_idle", 64'(o_busy), 64'd0);

        // Reset asserted during a WRITE cycle
        @(posedge clk);
        #1;
        i_req     = 2'b01;
        i_data0   = 64'hFEED_FACE_0000_0010;
        i_byteen0 = 8'h5A;
        sb.push_back('{2'b01, exp_addr, 64'hFEED_FACE_0000_0010, 8'h5A});
        wait_write(8, dummy);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_wbit", 64'(o_wbit), 64'd0);
        chk("rstw_ack", 64'(o_ack), 64'd0);
        i_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_addr", 64'(o_address), 64'd1);
        chk("rstw_wrapped", 64'(o_wrapped), 64'd0);
        chk("rstw_busy", 64'(o_busy), 64'd0);

        // Both requesting for four grants: alternate, 3 cycles apart, addresses 1..4
        @(posedge clk);
        #1;
        i_req     = 2'b11;
        i_data0   = 64'h0000_0000_0000_00A0;
        i_data1   = 64'h0000_0000_0000_00B1;
        i_byteen0 = 8'h0F;
        i_byteen1 = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            e.ack  = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.addr = ADDR_W'(i + 1);
            e.data = (i % 2 == 0) ? 64'h0000_0000_0000_00A0 : 64'h0000_0000_0000_00B1;
            e.be   = (i % 2 == 0) ? 8'h0F : 8'hF0;
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) wait_write(8, c[i]);
        @(posedge clk);
        #1 i_req = 2'b00;
        for (int i = 1; i < 4; i++) chk("spacing", 64'(c[i] - c[i-1]), 64'd3);
        @(posedge clk);
        @(negedge clk);
        chk("rr_addr_after", 64'(o_address), 64'd5);

        // Single write at the last address of the preloaded instance
        @(posedge clk);
        #1;
        w_req     = 2'b01;
        w_data0   = 64'hDEAD_BEEF_0000_0001;
        w_byteen0 = 8'h3C;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            if (w_wbit) seen = 1'b1;
        end
        chk("wrap_write_seen", 64'(seen), 64'd1);
        chk("wrap_wr_addr", 64'(w_address), 64'd16383);
        chk("wrap_wr_ack", 64'(w_ack), 64'b01);
        chk("wrap_wr_data", w_data, 64'hDEAD_BEEF_0000_0001);
`ifdef RAMWR_STOP_ON_FULL_EN
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("full_addr", 64'(w_address), 64'd16383);
        chk("full_wrapped", 64'(w_wrapped), 64'd1);
        chk("full_busy", 64'(w_busy), 64'd1);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w_ack != 2'b00 || w_wbit) acks++;
        end
        chk("full_no_grant", 64'(acks), 64'd0);
        chk("full_busy_hold", 64'(w_busy), 64'd1);
        w_req = 2'b00;
`else
        acks = 0;
        @(posedge clk);
        #1 w_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr", 64'(w_address), 64'd0);
        chk("wrap_wrapped", 64'(w_wrapped), 64'd1);
        chk("wrap_busy", 64'(w_busy), 64'd0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
